// File: rtl/uart_pkg.sv
// UART frame receiver shared types.
// FSM states, frame entry layout, data width.
package uart_pkg;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    typedef struct packed {
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received frames.
// Head reads as zero while empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data  = o_empty ? '0 : r_mem[r_rp];
    // A pop in the same cycle frees a slot for a push into a full FIFO.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/uart_frame_rx.sv
// UART receiver: start, 8 data LSB-first, even parity, stop.
// Frames and their error flags are queued in a small FIFO.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] out_data,
    output logic       out_parity_err,
    output logic       out_frame_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    input  logic       err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] MID_C  = CW'(MID);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [IW-1:0]        r_idx, w_idx;
    logic [DATA_BITS-1:0] r_sh, w_sh;
    logic                 r_par, w_par;
    logic                 r_perr, w_perr;
    logic                 r_ovr;
    logic                 w_tick;
    logic                 w_push;
    entry_t               w_entry;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_head;
    entry_t               w_head_e;

    assign w_tick = (r_cnt == LAST_C);

    // Next-state, bit timing and frame assembly.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_sh    = r_sh;
        w_par   = r_par;
        w_perr  = r_perr;
        w_push  = 1'b0;
        w_entry = '0;
        unique case (r_state)
            S_IDLE: begin
                if (!rx_serial) begin
                    w_idx = '0;
                    w_par = 1'b0;
                    if (MID == 0) begin
                        w_state = S_DATA;
                        w_cnt   = '0;
                    end else begin
                        w_state = S_START;
                        w_cnt   = CW'(1);
                    end
                end
            end
            S_START: begin
                if (r_cnt == MID_C) begin
                    w_cnt   = '0;
                    w_state = rx_serial ? S_IDLE : S_DATA;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_sh  = {rx_serial, r_sh[DATA_BITS-1:1]};
                    w_par = r_par ^ rx_serial;
                    w_cnt = '0;
                    w_idx = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) w_state = S_PARITY;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_perr  = rx_serial ^ r_par;
                    w_cnt   = '0;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_push             = 1'b1;
                    w_entry.frame_err  = !rx_serial;
                    w_entry.parity_err = r_perr;
                    w_entry.data       = r_sh;
                    w_cnt              = '0;
                    w_state            = rx_serial ? S_IDLE : S_BREAK;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_serial) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_sh    <= w_sh;
            r_par   <= w_par;
            r_perr  <= w_perr;
        end
    end

    assign w_pop  = out_valid && out_ready;
    assign w_drop = w_push && w_full && !w_pop;

    // Sticky overrun; a drop outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)          r_ovr <= 1'b0;
        else if (w_drop)  r_ovr <= 1'b1;
        else if (err_clr) r_ovr <= 1'b0;
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_head)
    );

    assign w_head_e       = w_head;
    assign out_data       = w_head_e.data;
    assign out_parity_err = w_head_e.parity_err;
    assign out_frame_err  = w_head_e.frame_err;
    assign out_valid      = !w_empty;
    assign overrun        = r_ovr;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx at 1 and 4 clocks per bit.
// Expected entries come from a frame-level model queue.
module tb_uart_frame_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx1 = 1'b1, rdy1 = 1'b0, clr1 = 1'b0;
    logic       rx4 = 1'b1, rdy4 = 1'b0, clr4 = 1'b0;
    logic [7:0] d1, d4;
    logic       pe1, fe1, v1, ov1;
    logic       pe4, fe4, v4, ov4;

    int errors = 0;
    int checks = 0;

    logic [9:0] q[$];
    logic       mov;

    always #5 clk = ~clk;

    uart_frame_rx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .rx_serial(rx1), .out_data(d1),
        .out_parity_err(pe1), .out_frame_err(fe1), .out_valid(v1),
        .out_ready(rdy1), .overrun(ov1), .err_clr(clr1)
    );

    uart_frame_rx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .rx_serial(rx4), .out_data(d4),
        .out_parity_err(pe4), .out_frame_err(fe4), .out_valid(v4),
        .out_ready(rdy4), .overrun(ov4), .err_clr(clr4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int cpb, input logic b);
        if (cpb == 1) rx1 = b;
        else          rx4 = b;
        tick(cpb);
    endtask

    function automatic logic [11:0] head(input int cpb);
        if (cpb == 1) return {ov1, v1, fe1, pe1, d1};
        return {ov4, v4, fe4, pe4, d4};
    endfunction

    // Sends one frame with ready low; the model queues what should land.
    task automatic send(input int cpb, input logic [7:0] d,
                        input logic pflip, input logic stop, input int hold);
        logic [11:0] h;
        logic        pbit;
        pbit = (^d) ^ pflip;
        drive_bit(cpb, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(cpb, d[i]);
        drive_bit(cpb, pbit);
        h = head(cpb);
        chk("valid_pre_stop", {31'd0, h[10]}, {31'd0, q.size() > 0});
        drive_bit(cpb, stop);
        if (q.size() < 4) q.push_back({~stop, pflip, d});
        else              mov = 1'b1;
        h = head(cpb);
        chk("valid_post_stop", {31'd0, h[10]}, {31'd0, q.size() > 0});
        chk("overrun", {31'd0, h[11]}, {31'd0, mov});
        if (!stop) begin
            drive_bit(cpb, 1'b0);
            if (hold > 1) tick(hold - 1);
            drive_bit(cpb, 1'b1);
        end
    endtask

    task automatic drain(input int cpb);
        logic [11:0] h;
        logic [9:0]  e;
        while (q.size() > 0) begin
            e = q.pop_front();
            h = head(cpb);
            chk("head_valid", {31'd0, h[10]}, 32'd1);
            chk("head_data", {24'd0, h[7:0]}, {24'd0, e[7:0]});
            chk("head_perr", {31'd0, h[8]}, {31'd0, e[8]});
            chk("head_ferr", {31'd0, h[9]}, {31'd0, e[9]});
            if (cpb == 1) rdy1 = 1'b1;
            else          rdy4 = 1'b1;
            tick(1);
            rdy1 = 1'b0;
            rdy4 = 1'b0;
        end
        h = head(cpb);
        chk("drained_empty", {31'd0, h[10]}, 32'd0);
    endtask

    task automatic clear_ovr();
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        mov  = 1'b0;
        chk("overrun_cleared", {31'd0, ov1}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, v1}, 32'd0);
        chk({tag, "_data"}, {24'd0, d1}, 32'd0);
        chk({tag, "_perr"}, {31'd0, pe1}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, fe1}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, ov1}, 32'd0);
    endtask

    initial begin
        int          n;
        logic [7:0]  rd;
        logic        rp, rs;
        mov = 1'b0;
        tick(2);
        rst = 1'b0;
        check_zero("reset");
        chk("reset_valid4", {31'd0, v4}, 32'd0);
        tick(2);

        send(1, 8'hA5, 1'b0, 1'b1, 0);
        drain(1);
        send(1, 8'h01, 1'b1, 1'b1, 0);
        drain(1);

        send(1, 8'h3C, 1'b0, 1'b0, 5);
        send(1, 8'h55, 1'b0, 1'b1, 0);
        drain(1);

        for (int i = 0; i < 5; i++) send(1, 8'(8'h10 + i), 1'b0, 1'b1, 0);
        chk("overrun_set", {31'd0, ov1}, 32'd1);
        drain(1);
        chk("overrun_sticky", {31'd0, ov1}, 32'd1);
        clear_ovr();

        rx4 = 1'b0;
        tick(1);
        rx4 = 1'b1;
        tick(6);
        chk("glitch_idle", {29'd0, u4.r_state}, {29'd0, S_IDLE});
        chk("glitch_nopush", {31'd0, v4}, 32'd0);
        send(4, 8'hC3, 1'b0, 1'b1, 0);
        drain(4);

        for (int b = 0; b < 4; b++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                rd = 8'($urandom);
                rp = ($urandom_range(0, 3) == 0);
                rs = ($urandom_range(0, 4) != 0);
                send(1, rd, rp, rs, $urandom_range(1, 4));
            end
            chk("rand_overrun", {31'd0, ov1}, {31'd0, mov});
            drain(1);
            if (mov) clear_ovr();
        end

        send(1, 8'h99, 1'b0, 1'b1, 0);
        drive_bit(1, 1'b0);
        drive_bit(1, 1'b0);
        drive_bit(1, 1'b1);
        drive_bit(1, 1'b1);
        drive_bit(1, 1'b0);
        rx1 = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q.delete();
        mov = 1'b0;
        check_zero("midreset");
        tick(2);
        send(1, 8'h7E, 1'b0, 1'b1, 0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Full-checking UART frame receiver. Decodes the 11-bit serial frame produced by the team's UART transmitter: start, 8 data bits LSB-first, even parity, stop. It checks parity and stop bit and buffers each decoded byte plus its error flags in a small FIFO with a valid/ready output handshake. It replaces the parity-ignoring receive path on the serial link between UART endpoints.

## Interface
- CLKS_PER_BIT, 1, clock cycles per serial bit; ≥1. Value 1 matches the existing transmitter (one bit per clock).
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_serial  in  1  serial line; idle high; same clock domain (no synchronizer).
- out_data  out  8  byte at FIFO head.
- out_parity_err  out  1  parity flag of head entry.
- out_frame_err  out  1  stop-bit flag of head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- err_clr  in  1  clears overrun.

## Operation
- Frame: start(0), D0..D7, P where P = XOR(D7..D0), stop(1). An odd number of ones gives P=1.
- MID = (CLKS_PER_BIT-1)/2, integer division. Bit counter cnt, bit index idx (0..7), shift register sh[7:0], parity accumulator.
- IDLE: on rx_serial==0, if MID==0 go DATA with cnt=0; else go START with cnt=1.
- START: when cnt==MID, go DATA with cnt=0 if rx_serial==0, else go IDLE (false start, nothing pushed). Otherwise cnt++.
- DATA: cnt++. At cnt==CLKS_PER_BIT-1: sample into sh, shifting right with MSB-in so D0 ends at bit 0; XOR into parity; cnt=0; idx++. After idx 7, go PARITY.
- PARITY: sample at the same point. parity_err = sampled bit != accumulated XOR. Go STOP.
- STOP: sample at the same point. frame_err = (rx_serial==0). Push {frame_err, parity_err, sh}. Go IDLE if the stop bit was 1; go BREAK if it was 0.
- BREAK: wait for rx_serial==1, then go IDLE. No start detection while in BREAK.
- Errored frames are still pushed, with their flags.
- Push when full: entry dropped, overrun<=1.
- Simultaneous push and pop when full: pop frees a slot, so the push is accepted and the count is unchanged.
- err_clr clears overrun. If err_clr and a drop occur in the same cycle, set wins.
- Pop: out_valid && out_ready advances the head.

## Timing
- Reset values: out_valid=0, out_data=0, out_parity_err=0, out_frame_err=0, overrun=0; FSM=IDLE; FIFO empty; cnt, idx, sh cleared.
- Reset mid-frame aborts the frame; no partial push.
- After reset, rx_serial==0 is treated as a start bit.
- Sample point: rx_serial value present before the active edge. Start midpoint at edge t; Dn sampled at t+(n+1)·CLKS_PER_BIT; parity at t+9·CPB; stop at t+10·CPB.
- Latency: FIFO written at the stop-sample edge. When the FIFO was empty, out_valid=1 and data are visible in the following cycle (registered FIFO count, show-ahead head).
- With CLKS_PER_BIT=1, back-to-back frames are supported. The cycle after the stop sample, FSM is in IDLE and may detect the next start.
- Counter widths: cnt is $clog2(CLKS_PER_BIT)+1 bits. FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider.

## Structure
- Shared package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK), DATA_BITS=8, frame entry struct {frame_err, parity_err, data[7:0]}.
- Sub-module uart_rx_fifo: synchronous FIFO parameterized on depth and entry width. It provides push/full/pop/empty and show-ahead head data.
- Top module holds the FSM, counters, parity, and overrun logic.

## Test plan
- CPB=1, send 0xA5 (bits 1,0,1,0,0,1,0,1, P=0, stop=1), out_ready=1 -> out_data=0xA5, both error flags 0, out_valid high exactly one cycle after the stop sample.
- CPB=1, send 0x01 with P=0 -> out_data=0x01, out_parity_err=1, out_frame_err=0.
- CPB=1, send 0x3C with stop=0, then hold rx low 5 cycles, then high, then a clean 0x55 -> first entry has out_frame_err=1. No spurious frames during the low hold. Second entry is 0x55 clean.
- FIFO_DEPTH=4, out_ready=0, send 0x10..0x14 -> four entries 0x10..0x13 held, overrun=1, 0x14 dropped. Pop all with out_ready=1 -> in-order drain. err_clr -> overrun=0.
- CPB=4, one-cycle low glitch on idle line -> no push, FSM back to IDLE. Then a valid 0xC3 frame at 4 cycles/bit -> 0xC3 clean.
- Assert rst during D4 of a frame, then send a clean 0x7E -> only 0x7E appears; all outputs are 0 in the cycle after reset.
